// File: rtl/fetch_pair_queue.sv
// Dual-instruction fetch front end: reads an instruction pair per cycle from a
// synchronous memory, buffers pairs in a small FIFO and presents the head pair.
module fetch_pair_queue #(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_rd_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_data1,
  input  logic [15:0]       imem_data2,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              stall_in,
  output logic [15:0]       instr1_out,
  output logic [15:0]       instr2_out,
  output logic              pair_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic              queue_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_REDIRECT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] infl_addr_q, infl_addr_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [15:0]       i1_mem [DEPTH];
  logic [15:0]       i2_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem [DEPTH];

  logic             deq;
  logic             enq;
  logic [CNT_W-1:0] occupancy;

  assign pair_valid = (count_q != '0);
  assign queue_full = (count_q == DEPTH_C);
  assign deq        = pair_valid & ~stall_in & ~redirect_valid;
  // A returning pair is dropped when a redirect flushes the queue in the same cycle.
  assign enq        = inflight_q & ~redirect_valid;
  assign occupancy  = count_q + CNT_W'(inflight_q) - CNT_W'(deq);
  assign imem_rd_en = (state_q == S_RUN) && (occupancy < DEPTH_C);
  assign imem_addr  = imem_rd_en ? fetch_pc_q : '0;

  assign instr1_out = pair_valid ? i1_mem[head_q] : 16'h0;
  assign instr2_out = pair_valid ? i2_mem[head_q] : 16'h0;
  assign pc_out     = pair_valid ? pc_mem[head_q] : '0;

  // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    inflight_d  = 1'b0;
    infl_addr_d = infl_addr_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;

    unique case (state_q)
      S_BOOT:     state_d = S_RUN;
      S_RUN:      state_d = redirect_valid ? S_REDIRECT : S_RUN;
      S_REDIRECT: state_d = redirect_valid ? S_REDIRECT : S_RUN;
      default:    state_d = S_BOOT;
    endcase

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (imem_rd_en) begin
        fetch_pc_d  = fetch_pc_q + ADDR_W'(2);
        inflight_d  = 1'b1;
        infl_addr_d = fetch_pc_q;
      end
      if (enq) tail_d = tail_q + 1'b1;
      if (deq) head_d = head_q + 1'b1;
      count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_BOOT;
      fetch_pc_q  <= RESET_PC;
      inflight_q  <= 1'b0;
      infl_addr_q <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      inflight_q  <= inflight_d;
      infl_addr_q <= infl_addr_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
    end
  end

  // NOTE: queue storage is not reset; count_q gates every read, so stale contents never escape.
  always_ff @(posedge clk) begin
    if (enq) begin
      i1_mem[tail_q] <= imem_data1;
      i2_mem[tail_q] <= imem_data2;
      pc_mem[tail_q] <= infl_addr_q;
    end
  end

endmodule
